// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch hazard controller: branch/state encodings,
// predictor reset value and the branch condition evaluation.
package branch_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_BEQ = 3'b000,
    BR_BLE = 3'b001,
    BR_BNE = 3'b010,
    BR_BLT = 3'b011
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_STALL   = 2'b10
  } state_e;

  localparam logic [1:0] PRED_RST = 2'b01;

  // Types 1xx are reserved and never taken.
  function automatic logic branch_taken(input logic [2:0] br_type,
                                        input logic zero, input logic neg);
    logic taken;
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = zero;
      BR_BLE:  taken = zero | neg;
      BR_BNE:  taken = ~zero;
      BR_BLT:  taken = neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Table of 2-bit saturating branch counters; lookup reads the pre-update value.
module branch_pred_table
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [2**IDX_W];

  assign lookup_taken = cnt[lookup_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**IDX_W; i++) begin
        cnt[IDX_W'(i)] <= PRED_RST;
      end
    end else if (upd_en) begin
      if (upd_taken && cnt[upd_idx] != 2'b11) begin
        cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      end else if (!upd_taken && cnt[upd_idx] != 2'b00) begin
        cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch capture/resolve controller with load-use stall and flush generation.
// Optional predictor table enabled by defining BRANCH_PRED_EN.
module branch_hazard_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned PRED_IDX_W = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic            id_branch_i,
  input  logic [2:0]      id_type_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic [PC_W-1:0] id_target_i,
  input  logic            id_uses_load_i,
  input  logic            ex_zero_i,
  input  logic            ex_neg_i,
  output logic            stall_o,
  output logic            flush_ifid_o,
  output logic            flush_idex_o,
  output logic            pc_sel_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            reserved_type_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  state_e          state;
  logic            rst_q;
  logic [2:0]      slot_type;
  logic [PC_W-1:0] slot_pc;
  logic [PC_W-1:0] slot_target;
  logic            slot_pred;
  logic [CNT_W-1:0] cnt;

  logic active;
  logic branch_in_id;
  logic resolving;
  logic taken;
  logic mispred;
  logic stall;
  logic capture;
  logic pred_taken;
  logic pred_redirect;

  // The cycle after reset is held quiet as well, so nothing is stalled or captured.
  assign active       = !rst_i && !rst_q;
  assign branch_in_id = id_valid_i && id_branch_i;
  assign resolving    = active && (state == ST_RESOLVE);
  assign taken        = branch_taken(slot_type, ex_zero_i, ex_neg_i);
  assign mispred      = resolving && (taken != slot_pred);
  assign stall        = active && branch_in_id && id_uses_load_i &&
                        (state != ST_STALL) && !mispred;
  assign capture      = active && branch_in_id && !mispred &&
                        ((state == ST_STALL) || !id_uses_load_i);
  assign pred_redirect = capture && pred_taken;

`ifdef BRANCH_PRED_EN
  branch_pred_table #(
    .IDX_W(PRED_IDX_W)
  ) u_pred (
    .clk          (clk_i),
    .rst          (rst_i),
    .lookup_idx   (id_pc_i[PRED_IDX_W+1:2]),
    .lookup_taken (pred_taken),
    .upd_en       (resolving && !slot_type[2]),
    .upd_idx      (slot_pc[PRED_IDX_W+1:2]),
    .upd_taken    (taken)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^PRED_IDX_W;
  assign pred_taken = 1'b0;
`endif

  always_comb begin
    stall_o         = stall;
    flush_ifid_o    = mispred || pred_redirect;
    flush_idex_o    = mispred;
    pc_sel_o        = mispred || pred_redirect;
    reserved_type_o = resolving && slot_type[2];
    mispred_cnt_o   = rst_i ? '0 : cnt;
    redirect_pc_o   = '0;
    if (mispred) begin
      redirect_pc_o = taken ? slot_target : slot_pc + PC_W'(4);
    end else if (pred_redirect) begin
      redirect_pc_o = id_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rst_q       <= 1'b1;
      cnt         <= '0;
      slot_type   <= '0;
      slot_pc     <= '0;
      slot_target <= '0;
      slot_pred   <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (mispred && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        state       <= ST_RESOLVE;
        slot_type   <= id_type_i;
        slot_pc     <= id_pc_i;
        slot_target <= id_target_i;
        slot_pred   <= pred_taken;
      end else if (stall) begin
        state <= ST_STALL;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed plus randomized bench for branch_hazard_ctrl against a cycle-level
// reference model; honours BRANCH_PRED_EN when defined.
module tb_branch_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_valid_i = 1'b0;
  logic        id_branch_i = 1'b0;
  logic [2:0]  id_type_i = '0;
  logic [31:0] id_pc_i = '0;
  logic [31:0] id_target_i = '0;
  logic        id_uses_load_i = 1'b0;
  logic        ex_zero_i = 1'b0;
  logic        ex_neg_i = 1'b0;
  logic        stall_o, flush_ifid_o, flush_idex_o, pc_sel_o, reserved_type_o;
  logic [31:0] redirect_pc_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model: one record for the branch in EX plus bookkeeping flags.
  bit          m_after_rst = 1'b0;
  bit          m_ex_valid = 1'b0;
  logic [2:0]  m_ex_type = '0;
  logic [31:0] m_ex_pc = '0;
  logic [31:0] m_ex_tgt = '0;
  bit          m_ex_pred = 1'b0;
  bit          m_bubble = 1'b0;
  int          m_cnt = 0;
  int          m_tbl [16];

  logic        o_stall, o_fi, o_fe, o_pcsel, o_res;
  logic [31:0] o_red;
  logic [31:0] o_cnt;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(
    .PC_W(32),
    .PRED_IDX_W(4),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_branch_i    (id_branch_i),
    .id_type_i      (id_type_i),
    .id_pc_i        (id_pc_i),
    .id_target_i    (id_target_i),
    .id_uses_load_i (id_uses_load_i),
    .ex_zero_i      (ex_zero_i),
    .ex_neg_i       (ex_neg_i),
    .stall_o        (stall_o),
    .flush_ifid_o   (flush_ifid_o),
    .flush_idex_o   (flush_idex_o),
    .pc_sel_o       (pc_sel_o),
    .redirect_pc_o  (redirect_pc_o),
    .reserved_type_o(reserved_type_o),
    .mispred_cnt_o  (mispred_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] t, input bit z, input bit n);
    case (t)
      3'd0:    return z;
      3'd1:    return z || n;
      3'd2:    return !z;
      3'd3:    return n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_after_rst = 1'b1;
    m_ex_valid  = 1'b0;
    m_bubble    = 1'b0;
    m_cnt       = 0;
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
  endtask

  // Drive one cycle of inputs, compare every output with the model, advance the model.
  task automatic run_cycle(input bit rst, input bit v, input bit b, input logic [2:0] t,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input bit ul, input bit z, input bit n);
    bit blocked, tk, mis, stall, cap, pred;
    bit e_pcsel, e_fi, e_fe, e_res;
    logic [31:0] e_red, e_cnt;
    int ex_idx;
    @(negedge clk);
    rst_i = rst; id_valid_i = v; id_branch_i = b; id_type_i = t;
    id_pc_i = pc; id_target_i = tgt; id_uses_load_i = ul;
    ex_zero_i = z; ex_neg_i = n;
    #1;
    blocked = rst || m_after_rst;
    tk = 0; mis = 0; stall = 0; cap = 0; pred = 0;
    e_pcsel = 0; e_fi = 0; e_fe = 0; e_res = 0; e_red = '0;
    e_cnt = rst ? 32'd0 : 32'(m_cnt);
    if (!blocked && m_ex_valid) begin
      tk    = ref_taken(m_ex_type, z, n);
      e_res = m_ex_type[2];
      if (tk != m_ex_pred) begin
        mis = 1; e_pcsel = 1; e_fi = 1; e_fe = 1;
        e_red = tk ? m_ex_tgt : m_ex_pc + 32'd4;
      end
    end
    if (!blocked && !mis && v && b) begin
      if (ul && !m_bubble) stall = 1;
      else begin
        cap = 1;
`ifdef BRANCH_PRED_EN
        pred = m_tbl[int'((pc >> 2) & 32'hF)] >= 2;
`endif
        if (pred) begin
          e_pcsel = 1; e_fi = 1; e_red = tgt;
        end
      end
    end
    o_stall = stall_o; o_fi = flush_ifid_o; o_fe = flush_idex_o; o_pcsel = pc_sel_o;
    o_res = reserved_type_o; o_red = redirect_pc_o; o_cnt = 32'(mispred_cnt_o);
    chk("stall", 32'(o_stall), 32'(stall));
    chk("flush_ifid", 32'(o_fi), 32'(e_fi));
    chk("flush_idex", 32'(o_fe), 32'(e_fe));
    chk("pc_sel", 32'(o_pcsel), 32'(e_pcsel));
    chk("redirect_pc", o_red, e_red);
    chk("reserved", 32'(o_res), 32'(e_res));
    chk("mispred_cnt", o_cnt, e_cnt);
    if (rst) model_reset();
    else begin
      m_after_rst = 1'b0;
      if (!blocked && m_ex_valid && !m_ex_type[2]) begin
        ex_idx = int'((m_ex_pc >> 2) & 32'hF);
        if (tk && m_tbl[ex_idx] < 3) m_tbl[ex_idx]++;
        if (!tk && m_tbl[ex_idx] > 0) m_tbl[ex_idx]--;
      end
      if (mis && m_cnt < CNT_MAX) m_cnt++;
      m_bubble   = stall;
      m_ex_valid = cap;
      if (cap) begin
        m_ex_type = t; m_ex_pc = pc; m_ex_tgt = tgt; m_ex_pred = pred;
      end
    end
  endtask

  initial begin
    // Reset held with branches present on the inputs.
    for (int i = 0; i < 3; i++) run_cycle(1, 1, 1, 3'd0, 32'h40, 32'h80, 1, 1, 1);
    chk("rst_cnt", o_cnt, 32'd0);
    chk("rst_pcsel", 32'(o_pcsel), 32'd0);
    run_cycle(0, 1, 1, 3'd0, 32'h40, 32'h80, 1, 1, 1);
    chk("post_rst_stall", 32'(o_stall), 32'd0);

    // beq taken, then a not-taken beq at a fresh pc.
    run_cycle(0, 1, 1, 3'd0, 32'h40, 32'h80, 0, 0, 0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 0);
    chk("beq_t_pcsel", 32'(o_pcsel), 32'd1);
    chk("beq_t_red", o_red, 32'h80);
    chk("beq_t_flush", {30'd0, o_fi, o_fe}, 32'd3);
    run_cycle(0, 1, 1, 3'd0, 32'h48, 32'h88, 0, 0, 0);
    chk("beq_cnt1", o_cnt, 32'd1);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    chk("beq_nt_pcsel", 32'(o_pcsel), 32'd0);

    // ble taken on N, bne / blt not taken, reserved type.
    run_cycle(0, 1, 1, 3'd1, 32'h50, 32'h90, 0, 0, 0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 1);
    chk("ble_red", o_red, 32'h90);
    run_cycle(0, 1, 1, 3'd2, 32'h60, 32'h94, 0, 0, 0);
    run_cycle(0, 1, 1, 3'd3, 32'h64, 32'h98, 0, 1, 0);
    chk("bne_nt", 32'(o_pcsel), 32'd0);
    run_cycle(0, 1, 1, 3'd5, 32'h68, 32'h9C, 0, 0, 0);
    chk("blt_nt", 32'(o_pcsel), 32'd0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 1);
    chk("rsv_pulse", 32'(o_res), 32'd1);
    chk("rsv_pcsel", 32'(o_pcsel), 32'd0);

    // Load-use: one stall, capture on the retry, resolve after.
    run_cycle(0, 1, 1, 3'd0, 32'h70, 32'hA0, 1, 0, 0);
    chk("lu_stall", 32'(o_stall), 32'd1);
    run_cycle(0, 1, 1, 3'd0, 32'h70, 32'hA0, 1, 0, 0);
    chk("lu_no_2nd", 32'(o_stall), 32'd0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 0);
    chk("lu_resolve", o_red, 32'hA0);

    // Back-to-back capture, then a mispredict dropping the wrong-path branch.
    run_cycle(0, 1, 1, 3'd2, 32'h74, 32'hA4, 0, 0, 0);
    run_cycle(0, 1, 1, 3'd0, 32'h78, 32'hB0, 0, 1, 0);
    chk("b2b_pcsel", 32'(o_pcsel), 32'd0);
    run_cycle(0, 1, 1, 3'd0, 32'h7C, 32'hB4, 1, 1, 0);
    chk("drop_red", o_red, 32'hB0);
    chk("drop_stall", 32'(o_stall), 32'd0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 0);
    chk("drop_idle", 32'(o_pcsel), 32'd0);

`ifdef BRANCH_PRED_EN
    run_cycle(1, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    run_cycle(0, 1, 1, 3'd0, 32'h40, 32'h80, 0, 0, 0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 0);
    run_cycle(0, 1, 1, 3'd0, 32'h40, 32'h80, 0, 0, 0);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 1, 0);
    run_cycle(0, 1, 1, 3'd0, 32'h40, 32'h80, 0, 0, 0);
    chk("pred_red", o_red, 32'h80);
    chk("pred_flush", {30'd0, o_fi, o_fe}, 32'd2);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    chk("pred_nt_red", o_red, 32'h44);
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    chk("pred_cnt", o_cnt, 32'd2);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(63)) << 2;
      run_cycle(1'($urandom_range(63) == 0), 1'($urandom_range(3) != 0),
                1'($urandom_range(1)), 3'($urandom_range(7)), rpc,
                $urandom & 32'hFFFF_FFFC, 1'($urandom_range(2) == 0),
                1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Drive enough mispredicts to saturate the counter.
    for (int i = 0; i < 40; i++) begin
      bit tz;
`ifdef BRANCH_PRED_EN
      tz = 1'(i % 2);
`else
      tz = 1'b1;
`endif
      run_cycle(0, 1, 1, 3'd0, 32'h40, 32'h80, 0, 0, 0);
      run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, tz, 0);
    end
    run_cycle(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    chk("cnt_sat", o_cnt, 32'(CNT_MAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences conditional branches through the 5-stage pipeline core.
- Captures a branch in ID and resolves it in EX from the ALU zero/sign flags.
- Drives PC redirect, IF/ID and ID/EX flushes, and the load-use stall on branch operands.
- Replaces the purely combinational branch-condition select of the single-cycle core with a registered, hazard-aware controller.

Parameters:
PC_W, 32, width of PC and branch target
PRED_IDX_W, 4, log2 of predictor table depth (used only with BRANCH_PRED_EN)
CNT_W, 16, width of misprediction counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
id_valid_i  in  1  ID-stage instruction valid
id_branch_i  in  1  ID instruction is a conditional branch
id_type_i  in  3  branch type: 000 beq, 001 ble, 010 bne, 011 blt, 1xx reserved
id_pc_i  in  PC_W  PC of ID instruction
id_target_i  in  PC_W  computed branch target of ID instruction
id_uses_load_i  in  1  a branch source register is the destination of the load now in EX
ex_zero_i  in  1  ALU zero flag (rs-rt==0) for instruction in EX
ex_neg_i  in  1  ALU sign flag (rs-rt<0) for instruction in EX
stall_o  out  1  hold PC and IF/ID, bubble into ID/EX
flush_ifid_o  out  1  squash IF/ID
flush_idex_o  out  1  squash ID/EX
pc_sel_o  out  1  1: next PC = redirect_pc_o
redirect_pc_o  out  PC_W  redirect address
reserved_type_o  out  1  pulse: reserved type resolved
mispred_cnt_o  out  CNT_W  saturating misprediction count

Behaviour:
- Reset: state IDLE, EX slot invalid, counter 0. Every output is 0 in the reset cycle and in the first cycle after reset.
- States:
  - IDLE: no branch in EX.
  - RESOLVE: a captured branch sits in EX.
  - STALL: one load-use bubble.
- Load-use stall: in IDLE or RESOLVE, id_valid_i & id_branch_i & id_uses_load_i gives stall_o=1 for exactly one cycle and enters STALL; the branch is not captured.
- STALL always exits the next cycle. If a branch is still in ID (id_valid_i & id_branch_i), it is captured with no second stall and the state becomes RESOLVE; otherwise IDLE.
- Capture: id_valid_i & id_branch_i & no stall & no flush this cycle. Latches type, pc, target and prediction into the EX slot; next state RESOLVE, else IDLE.
- Resolve (combinational on slot plus EX flags, same cycle):
  - Condition taken = beq Z; ble Z|N; bne ~Z; blt N; 1xx never taken, with reserved_type_o=1.
  - Misprediction = taken != predicted.
  - On misprediction: pc_sel_o=1, flush_ifid_o=1, flush_idex_o=1; redirect_pc_o = taken ? target : pc+4 (mod 2^PC_W); counter +1, saturating at all-ones.
- Priority: reset > mispredict flush > load-use stall > capture > prediction redirect.
  - A branch in ID during a mispredict cycle is wrong-path and is dropped.
- Back-to-back branches: a correctly resolved EX branch plus a new ID branch gives capture, staying in RESOLVE.
- Outputs not asserted are 0; redirect_pc_o is 0 when pc_sel_o=0.

Optional Feature:
BRANCH_PRED_EN
- Without it: prediction is always not-taken; the only redirect is on a taken branch in EX.
- With it, the predictor is a table of 2^PRED_IDX_W 2-bit saturating counters:
  - Indexed by pc[PRED_IDX_W+1:2]; every entry resets to 01.
  - Lookup at capture; counter >= 10 predicts taken.
  - A predicted-taken capture drives pc_sel_o=1, redirect_pc_o=id_target_i and flush_ifid_o=1 in the capture cycle, only if no higher-priority event.
  - Update at resolve: +1 if taken, -1 if not, saturating.
  - Same-index lookup and update in one cycle: lookup sees the pre-update value.
  - Reserved types never update.

Decomposition:
- Package branch_ctrl_pkg: branch type encodings, state encodings, predictor reset value 2'b01, and a condition-evaluation function (type, Z, N -> taken).
- Sub-module branch_pred_table: the counter array with lookup/update ports, instantiated only under BRANCH_PRED_EN.

Test Plan:
- Reset held 3 cycles with branches on inputs -> all outputs 0; mispred_cnt_o=0.
- beq at pc 0x40, target 0x80, then Z=1 in EX -> next cycle: pc_sel_o=1, redirect_pc_o=0x80, both flushes set, count=1. Repeat with Z=0 -> no redirect.
- ble with Z=0,N=1 -> taken. bne with Z=1 -> not taken. blt with N=0 -> not taken. Type 101 -> reserved_type_o pulse, no redirect.
- Branch with id_uses_load_i=1 -> stall_o=1 for exactly one cycle, capture next cycle, resolve the cycle after.
- Taken mispredict in EX while a second branch is in ID -> second branch dropped, state IDLE. Correct resolution with a branch in ID -> stays in RESOLVE.
- BRANCH_PRED_EN: pc 0x40 taken twice -> entry 01->10->11. Third capture redirects to target in ID with flush_ifid_o only. Not taken at resolve -> redirect 0x44, count increments. Force 2^CNT_W mispredicts -> saturates at 0xFFFF.
